uart_tx_fifo: RTL and testbench



---
 rtl/hqc_uart_pkg.sv | 15 +
 rtl/uart_byte_fifo.sv | 65 ++++++
 rtl/uart_tx_fifo.sv | 135 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hqc_uart_pkg.sv
// Shared types and constants for the HQC decapsulation wrapper UART blocks.
package hqc_uart_pkg;

   localparam int UART_DATA_BITS       = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 434;
   localparam int DEFAULT_FIFO_DEPTH   = 16;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO; full/empty come from the occupancy count, pointers wrap naturally.
module uart_byte_fifo
   import hqc_uart_pkg::*;
#(
   parameter int DEPTH = DEFAULT_FIFO_DEPTH,
   parameter int WIDTH = UART_DATA_BITS
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic [CW-1:0]    count_next;
   logic             do_push;
   logic             do_pop;

   assign full     = (count_reg == CW'(DEPTH));
   assign empty    = (count_reg == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign count    = count_reg;
   // Head is read combinationally so the transmitter can load it on the pop edge.
   assign pop_data = mem[rd_ptr_reg];

   always_comb begin
      count_next = count_reg;
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: queued bytes leave LSB first with no gap between frames.
module uart_tx_fifo
   import hqc_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [UART_DATA_BITS-1:0]     in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);

   tx_state_t                 state_reg, state_next;
   logic [BAUD_W-1:0]         baud_reg, baud_next;
   logic [2:0]                bit_reg, bit_next;
   logic [UART_DATA_BITS-1:0] shreg_reg, shreg_next;
   logic                      tx_reg, tx_next;
   logic                      pop;
   logic                      bit_done;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [UART_DATA_BITS-1:0] head;

   uart_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_valid),
      .push_data (in_data),
      .pop       (pop),
      .pop_data  (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign in_ready = !fifo_full;
   assign tx       = tx_reg;
   assign busy     = (state_reg != IDLE) || !fifo_empty;
   assign bit_done = (baud_reg == BAUD_W'(CLKS_PER_BIT - 1));

   // tx_next is the line level for the cycle that starts at the coming edge.
   always_comb begin
      state_next = state_reg;
      baud_next  = baud_reg;
      bit_next   = bit_reg;
      shreg_next = shreg_reg;
      tx_next    = tx_reg;
      pop        = 1'b0;
      case (state_reg)
         IDLE: begin
            tx_next   = 1'b1;
            baud_next = '0;
            if (!fifo_empty) begin
               pop        = 1'b1;
               shreg_next = head;
               state_next = START;
               tx_next    = 1'b0;
            end
         end
         START: begin
            if (bit_done) begin
               baud_next  = '0;
               bit_next   = '0;
               state_next = DATA;
               tx_next    = shreg_reg[0];
            end else begin
               baud_next = baud_reg + BAUD_W'(1);
            end
         end
         DATA: begin
            if (bit_done) begin
               baud_next  = '0;
               shreg_next = shreg_reg >> 1;
               if (bit_reg == 3'(UART_DATA_BITS - 1)) begin
                  state_next = STOP;
                  tx_next    = 1'b1;
               end else begin
                  bit_next = bit_reg + 3'd1;
                  tx_next  = shreg_reg[1];
               end
            end else begin
               baud_next = baud_reg + BAUD_W'(1);
            end
         end
         STOP: begin
            if (bit_done) begin
               baud_next = '0;
               // Chain straight into the next start bit when more data is waiting.
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  shreg_next = head;
                  state_next = START;
                  tx_next    = 1'b0;
               end else begin
                  state_next = IDLE;
                  tx_next    = 1'b1;
               end
            end else begin
               baud_next = baud_reg + BAUD_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            tx_next    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         baud_reg  <= '0;
         bit_reg   <= '0;
         shreg_reg <= '0;
         tx_reg    <= 1'b1;
      end else begin
         state_reg <= state_next;
         baud_reg  <= baud_next;
         bit_reg   <= bit_next;
         shreg_reg <= shreg_next;
         tx_reg    <= tx_next;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a frame-timeline model and a line decoder.
module tb_uart_tx_fifo;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int FRAME = 10 * CPB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    in_data = 8'h00;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          tx;
   logic          busy;
   logic [CW-1:0] fifo_count;

   int n_vec = 0;
   int n_err = 0;
   int now_e = 0;

   // Model: each accepted byte has an accept edge and the edge its start bit begins.
   int         acc_q[$];
   int         st_q[$];
   logic [7:0] dat_q[$];

   // Line decoder fed only by tx.
   bit         mon_act = 1'b0;
   int         mon_cnt = 0;
   logic [7:0] mon_sh = 8'h00;
   logic [7:0] mon_q[$];
   int         mon_t[$];

   uart_tx_fifo #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst) begin
         mon_act = 1'b0;
      end else if (!mon_act) begin
         if (tx === 1'b0) begin
            mon_act = 1'b1;
            mon_cnt = 0;
            mon_t.push_back(now_e);
         end
      end else begin
         mon_cnt++;
         if ((mon_cnt % CPB) == CPB / 2 && mon_cnt / CPB >= 1 && mon_cnt / CPB <= 8)
            mon_sh[mon_cnt / CPB - 1] = tx;
         if (mon_cnt == 9 * CPB + CPB / 2) begin
            mon_act = 1'b0;
            mon_q.push_back(mon_sh);
         end
      end
   end

   function automatic int m_count(int t);
      int c = 0;
      foreach (acc_q[i]) begin
         if (acc_q[i] <= t) c++;
         if (st_q[i] <= t) c--;
      end
      return c;
   endfunction

   function automatic logic m_active(int t);
      foreach (st_q[i]) if (t >= st_q[i] && t < st_q[i] + FRAME) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic m_tx(int t);
      foreach (st_q[i]) begin
         if (t >= st_q[i] && t < st_q[i] + FRAME) begin
            int b;
            logic [7:0] d;
            b = (t - st_q[i]) / CPB;
            d = dat_q[i];
            if (b == 0) return 1'b0;
            if (b == 9) return 1'b1;
            return d[b - 1];
         end
      end
      return 1'b1;
   endfunction

   function automatic logic m_busy(int t);
      return (m_count(t) != 0) || m_active(t);
   endfunction

   function automatic logic m_ready(int t);
      return m_count(t) < DEPTH;
   endfunction

   // Advance one edge, update the model, leave the bench 1 time unit past the edge.
   task automatic tick();
      logic rdy;
      rdy = m_ready(now_e);
      @(posedge clk);
      now_e++;
      if (rst) begin
         acc_q.delete();
         st_q.delete();
         dat_q.delete();
      end else if (in_valid && rdy) begin
         int s;
         s = now_e + 1;
         if (st_q.size() > 0 && st_q[$] + FRAME > s) s = st_q[$] + FRAME;
         acc_q.push_back(now_e);
         st_q.push_back(s);
         dat_q.push_back(in_data);
         $display("push 0x%02h accepted at edge %0d, start bit at edge %0d", in_data, now_e, s);
      end
      #1;
   endtask

   task automatic model_flush();
      acc_q.delete();
      st_q.delete();
      dat_q.delete();
      mon_q.delete();
      mon_t.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (3) tick();
      n_vec += 4;
      if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", in_ready); end
      if (fifo_count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         n_vec++;
         if (tx !== 1'b1) begin n_err++; $display("FAIL idle_tx edge %0d: got %b want 1", now_e, tx); end
      end
   endtask

   task automatic test_single();
      int n;
      int fall_e;
      model_flush();
      fall_e = -1;
      in_data = 8'hA5;
      in_valid = 1'b1;
      tick();
      n = now_e;
      in_valid = 1'b0;
      for (int i = 0; i < 50; i++) begin
         logic busy_prev;
         busy_prev = busy;
         tick();
         if (busy_prev && !busy && fall_e < 0) fall_e = now_e;
         n_vec++;
         if ({tx, busy, in_ready, fifo_count} !== {m_tx(now_e), m_busy(now_e), m_ready(now_e), CW'(m_count(now_e))}) begin
            n_err++;
            $display("FAIL single edge %0d: dut tx/busy/rdy/cnt=%b/%b/%b/%0d model=%b/%b/%b/%0d", now_e,
                     tx, busy, in_ready, fifo_count, m_tx(now_e), m_busy(now_e), m_ready(now_e), m_count(now_e));
         end
      end
      n_vec++;
      if (fall_e != n + 41) begin n_err++; $display("FAIL single_busy_fall: got edge %0d want %0d", fall_e, n + 41); end
      n_vec++;
      if (mon_q.size() != 1 || mon_q[0] !== 8'hA5) begin
         n_err++; $display("FAIL single_decode: got %0d bytes first 0x%02h want 0xa5", mon_q.size(), mon_q.size() > 0 ? mon_q[0] : 8'h00);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] pat [3];
      pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h55;
      model_flush();
      for (int i = 0; i < 3; i++) begin
         in_data = pat[i];
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 3 * FRAME + 5; i++) begin
         tick();
         n_vec++;
         if ({tx, busy, in_ready, fifo_count} !== {m_tx(now_e), m_busy(now_e), m_ready(now_e), CW'(m_count(now_e))}) begin
            n_err++;
            $display("FAIL b2b edge %0d: dut tx/busy/rdy/cnt=%b/%b/%b/%0d model=%b/%b/%b/%0d", now_e,
                     tx, busy, in_ready, fifo_count, m_tx(now_e), m_busy(now_e), m_ready(now_e), m_count(now_e));
         end
      end
      n_vec++;
      if (mon_t.size() != 3 || mon_t[2] - mon_t[0] != 2 * FRAME) begin
         n_err++; $display("FAIL b2b_spacing: got %0d frames span %0d want 3 frames span %0d", mon_t.size(),
                           mon_t.size() == 3 ? mon_t[2] - mon_t[0] : -1, 2 * FRAME);
      end
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (i >= mon_q.size() || mon_q[i] !== pat[i]) begin
            n_err++; $display("FAIL b2b_decode[%0d]: got 0x%02h want 0x%02h", i, i < mon_q.size() ? mon_q[i] : 8'h00, pat[i]);
         end
      end
   endtask

   task automatic test_full();
      bit saw_full;
      saw_full = 1'b0;
      model_flush();
      for (int i = 0; i < 6; i++) begin
         in_data = 8'($urandom);
         in_valid = 1'b1;
         tick();
         if (!in_ready) saw_full = 1'b1;
      end
      in_valid = 1'b0;
      for (int i = 0; i < 6 * FRAME; i++) begin
         tick();
         n_vec++;
         if ({tx, busy, in_ready, fifo_count} !== {m_tx(now_e), m_busy(now_e), m_ready(now_e), CW'(m_count(now_e))}) begin
            n_err++;
            $display("FAIL full edge %0d: dut tx/busy/rdy/cnt=%b/%b/%b/%0d model=%b/%b/%b/%0d", now_e,
                     tx, busy, in_ready, fifo_count, m_tx(now_e), m_busy(now_e), m_ready(now_e), m_count(now_e));
         end
      end
      n_vec++;
      if (!saw_full) begin n_err++; $display("FAIL full_ready_drop: got in_ready never low want low once"); end
      n_vec++;
      if (mon_q.size() != dat_q.size()) begin
         n_err++; $display("FAIL full_count: got %0d frames want %0d", mon_q.size(), dat_q.size());
      end
      foreach (dat_q[i]) begin
         n_vec++;
         if (i >= mon_q.size() || mon_q[i] !== dat_q[i]) begin
            n_err++; $display("FAIL full_decode[%0d]: got 0x%02h want 0x%02h", i, i < mon_q.size() ? mon_q[i] : 8'h00, dat_q[i]);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [CW-1:0] cnt_pre;
      logic [7:0]    exp_b [3];
      model_flush();
      for (int i = 0; i < 3; i++) exp_b[i] = 8'($urandom);
      for (int i = 0; i < 2; i++) begin
         in_data = exp_b[i];
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      while (now_e < st_q[1] - 1) tick();
      cnt_pre = fifo_count;
      in_data = exp_b[2];
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_vec++;
      if (fifo_count !== cnt_pre || fifo_count !== CW'(1)) begin
         n_err++; $display("FAIL simul_count: got %0d before %0d want 1 both", fifo_count, cnt_pre);
      end
      for (int i = 0; i < 2 * FRAME + 5; i++) begin
         tick();
         n_vec++;
         if ({tx, busy, in_ready, fifo_count} !== {m_tx(now_e), m_busy(now_e), m_ready(now_e), CW'(m_count(now_e))}) begin
            n_err++;
            $display("FAIL simul edge %0d: dut tx/busy/rdy/cnt=%b/%b/%b/%0d model=%b/%b/%b/%0d", now_e,
                     tx, busy, in_ready, fifo_count, m_tx(now_e), m_busy(now_e), m_ready(now_e), m_count(now_e));
         end
      end
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (i >= mon_q.size() || mon_q[i] !== exp_b[i]) begin
            n_err++; $display("FAIL simul_decode[%0d]: got 0x%02h want 0x%02h", i, i < mon_q.size() ? mon_q[i] : 8'h00, exp_b[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      model_flush();
      in_data = 8'h3C;
      in_valid = 1'b1;
      tick();
      for (int i = 0; i < 2; i++) begin
         in_data = 8'($urandom);
         tick();
      end
      in_valid = 1'b0;
      while (now_e < st_q[0] + CPB + 3 * CPB + 1) tick();
      n_vec++;
      if (fifo_count !== CW'(2)) begin n_err++; $display("FAIL rstmid_queued: got %0d want 2", fifo_count); end
      rst = 1'b1;
      tick();
      n_vec += 3;
      if (tx !== 1'b1) begin n_err++; $display("FAIL rstmid_tx: got %b want 1", tx); end
      if (fifo_count !== '0) begin n_err++; $display("FAIL rstmid_count: got %0d want 0", fifo_count); end
      if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      rst = 1'b0;
      tick();
      model_flush();
      in_data = 8'h81;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < FRAME + 5; i++) begin
         tick();
         n_vec++;
         if ({tx, busy, in_ready, fifo_count} !== {m_tx(now_e), m_busy(now_e), m_ready(now_e), CW'(m_count(now_e))}) begin
            n_err++;
            $display("FAIL rstmid edge %0d: dut tx/busy/rdy/cnt=%b/%b/%b/%0d model=%b/%b/%b/%0d", now_e,
                     tx, busy, in_ready, fifo_count, m_tx(now_e), m_busy(now_e), m_ready(now_e), m_count(now_e));
         end
      end
      n_vec++;
      if (mon_q.size() != 1 || mon_q[0] !== 8'h81) begin
         n_err++; $display("FAIL rstmid_decode: got %0d bytes first 0x%02h want 0x81", mon_q.size(), mon_q.size() > 0 ? mon_q[0] : 8'h00);
      end
   endtask

   task automatic test_random();
      model_flush();
      for (int i = 0; i < 800 + 6 * FRAME; i++) begin
         if (i < 800) begin
            in_valid = ($urandom_range(0, 9) == 0);
            in_data  = 8'($urandom);
         end else begin
            in_valid = 1'b0;
         end
         tick();
         n_vec++;
         if ({tx, busy, in_ready, fifo_count} !== {m_tx(now_e), m_busy(now_e), m_ready(now_e), CW'(m_count(now_e))}) begin
            n_err++;
            $display("FAIL random edge %0d: dut tx/busy/rdy/cnt=%b/%b/%b/%0d model=%b/%b/%b/%0d", now_e,
                     tx, busy, in_ready, fifo_count, m_tx(now_e), m_busy(now_e), m_ready(now_e), m_count(now_e));
         end
      end
      n_vec++;
      if (mon_q.size() != dat_q.size()) begin
         n_err++; $display("FAIL random_count: got %0d frames want %0d", mon_q.size(), dat_q.size());
      end
      foreach (dat_q[i]) begin
         n_vec++;
         if (i >= mon_q.size() || mon_q[i] !== dat_q[i]) begin
            n_err++; $display("FAIL random_decode[%0d]: got 0x%02h want 0x%02h", i, i < mon_q.size() ? mon_q[i] : 8'h00, dat_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
